// File: rtl/led_pattern_reader.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_reader
// Description : Steps through an LED pattern ROM and drives the board LEDs.
//               Each pattern is fetched (address + enable), captured after
//               the ROM's one-cycle read latency, then held for CLK_DIV
//               cycles before the address steps forward or backward with
//               wrap-around.
//
// Ports       : clk       - system clock
//               rst       - asynchronous active-high reset
//               run       - level; 1 = sequence runs, 0 = stop after hold
//               dir       - 0 = address increments, 1 = address decrements
//               restart   - one-cycle pulse; return to address 0
//               rom_addr  - address to pattern ROM
//               rom_en    - ROM port enable
//               rom_data  - ROM read data (valid one cycle after fetch)
//               leds      - registered LED drive
//               step      - one-cycle pulse when leds is loaded
//               busy      - high in every state except IDLE
//
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_reader #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 4,
    parameter int CLK_DIV   = 50000000,
    parameter int ADDR_LAST = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              dir,
    input  logic              restart,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] leds,
    output logic              step,
    output logic              busy
);

    // Sized so that CLK_DIV-1 always fits; the counter never counts up.
    localparam int                 C_CNT_W     = $clog2(CLK_DIV + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD  = C_CNT_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0]  C_ADDR_LAST = ADDR_W'(ADDR_LAST);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [ADDR_W-1:0]   w_addr_adv;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0]   r_leds;
    logic [DATA_W-1:0]   w_leds_nxt;
    logic                r_step;
    logic                w_step_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_cnt  <= '0;
            r_leds <= '0;
            r_step <= 1'b0;
        end else begin
            r_addr <= w_addr_nxt;
            r_cnt  <= w_cnt_nxt;
            r_leds <= w_leds_nxt;
            r_step <= w_step_nxt;
        end
    end

    // Next address at hold expiry; dir is only looked at here, so a change
    // during the hold takes effect at the following advance.
    always_comb begin
        w_addr_adv = r_addr;
        if (dir) begin
            w_addr_adv = (r_addr == '0) ? C_ADDR_LAST : (r_addr - ADDR_W'(1));
        end else begin
            w_addr_adv = (r_addr == C_ADDR_LAST) ? '0 : (r_addr + ADDR_W'(1));
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_leds_nxt  = r_leds;
        w_step_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                // ROM output is valid this cycle; load LEDs and start hold.
                w_leds_nxt  = rom_data;
                w_step_nxt  = 1'b1;
                w_cnt_nxt   = C_CNT_LOAD;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    if (run) begin
                        w_addr_nxt  = w_addr_adv;
                        w_state_nxt = S_FETCH;
                    end else begin
                        // Stopping keeps the address so a resume refetches
                        // the pattern currently shown.
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - C_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // restart overrides everything above, including an expiry or a
        // capture landing in the same cycle; the LEDs keep their value.
        if (restart) begin
            w_addr_nxt  = '0;
            w_cnt_nxt   = '0;
            w_leds_nxt  = r_leds;
            w_step_nxt  = 1'b0;
            w_state_nxt = run ? S_FETCH : S_IDLE;
        end
    end

    // Enable and busy decode straight from the state register so that an
    // asynchronous reset clears them without waiting for a clock edge.
    assign rom_en   = (r_state == S_FETCH) || (r_state == S_CAPTURE);
    assign busy     = (r_state != S_IDLE);
    assign rom_addr = r_addr;
    assign leds     = r_leds;
    assign step     = r_step;

endmodule
`default_nettype wire
